// File: rtl/counter_sched.sv
// Time-shares one external free-running counter among NREQ requesters.
// Requesters are served round-robin. Each done pulse marks the end of that requester's delay.
module counter_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_delay,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic                  cnt_clr,
  output logic                  cnt_en,
  input  logic [WIDTH-1:0]      cnt_value
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = IW + 1;
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_DONE} state_t;

  state_t            state, state_d;
  logic [IW-1:0]     rr_ptr, rr_ptr_d;
  logic [IW-1:0]     owner, owner_d;
  logic [IW-1:0]     sel, next_owner;
  logic [WIDTH-1:0]  target, target_d;
  logic [NREQ-1:0]   gnt_d, done_d;
  logic              found;
  logic [WIDTH-1:0]  delay_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_delay
    assign delay_arr[g] = req_delay[g*WIDTH +: WIDTH];
  end

  // Scan rr_ptr, rr_ptr+1, ... (mod NREQ) and take the first pending request.
  always_comb begin
    logic [SW-1:0] sum;
    sel   = rr_ptr;
    found = 1'b0;
    sum   = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, rr_ptr} + SW'(i);
      if (sum >= SW'(NREQ)) sum = sum - SW'(NREQ);
      if (!found && req[sum[IW-1:0]]) begin
        found = 1'b1;
        sel   = sum[IW-1:0];
      end
    end
  end

  assign next_owner = (owner == IW'(NREQ - 1)) ? '0 : owner + IW'(1);
  assign busy       = (state != S_IDLE);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no branch can infer a latch.
    state_d  = state;
    owner_d  = owner;
    target_d = target;
    rr_ptr_d = rr_ptr;
    gnt_d    = gnt;
    done_d   = '0;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (found) begin
          owner_d  = sel;
          target_d = delay_arr[sel];
          gnt_d    = ONE << sel;
          state_d  = S_CLEAR;
        end
      end
      S_CLEAR: begin
        cnt_clr = 1'b1;
        if (!req[owner]) begin
          state_d  = S_IDLE;
          gnt_d    = '0;
          rr_ptr_d = next_owner;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // A dropped request abandons the job silently; the counter is left frozen.
        if (!req[owner]) begin
          state_d  = S_IDLE;
          gnt_d    = '0;
          rr_ptr_d = next_owner;
        end else if (cnt_value == target) begin
          state_d = S_DONE;
          done_d  = gnt;
        end else begin
          cnt_en = 1'b1;
        end
      end
      S_DONE: begin
        state_d  = S_IDLE;
        gnt_d    = '0;
        rr_ptr_d = next_owner;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      rr_ptr <= '0;
      owner  <= '0;
      target <= '0;
      gnt    <= '0;
      done   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state  <= state_d;
      rr_ptr <= rr_ptr_d;
      owner  <= owner_d;
      target <= target_d;
      gnt    <= gnt_d;
      done   <= done_d;
    end
  end

endmodule

// File: tb/tb_counter_sched.sv
// Bench for counter_sched: runs directed scenarios, then random traffic checked against a job-level model.
// A simple clear/enable counter stands in for the shared counter datapath.
module tb_counter_sched;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] req_delay = '0;
  logic [NREQ-1:0]       gnt, done;
  logic                  busy, cnt_clr, cnt_en;
  logic [WIDTH-1:0]      cnt_value;
  logic                  wrapped;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  counter_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .req(req), .req_delay(req_delay),
    .gnt(gnt), .done(done), .busy(busy), .cnt_clr(cnt_clr),
    .cnt_en(cnt_en), .cnt_value(cnt_value)
  );

  always @(posedge clk or negedge reset) begin
    if (!reset)       cnt_value <= '0;
    else if (cnt_clr) cnt_value <= '0;
    else if (cnt_en)  cnt_value <= cnt_value + 1'b1;
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) wrapped <= 1'b0;
    else if (cnt_en && cnt_value == {WIDTH{1'b1}}) wrapped <= 1'b1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic set_delay(input int i, input logic [WIDTH-1:0] d);
    req_delay[i*WIDTH +: WIDTH] = d;
  endtask

  // Waits for the next grant edge (a zero-to-nonzero gnt transition) and checks who received the grant.
  task automatic wait_grant(input int exp_idx, input string tag);
    int  got;
    bit  seen_zero;
    got = -1;
    seen_zero = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if (gnt == '0) seen_zero = 1'b1;
      else if (seen_zero) begin
        got = idx_of(gnt);
        break;
      end
      @(negedge clk);
    end
    check(tag, got, exp_idx);
  endtask

  task automatic wait_done(input logic [NREQ-1:0] exp, input string tag);
    for (int k = 0; k < 600; k++) begin
      if (done != '0) break;
      @(negedge clk);
    end
    check(tag, done, exp);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Job-level reference state for the random phase.
  int              m_left, m_owner, m_ptr;
  bit              r_req [NREQ];
  int              r_del [NREQ];
  int              gcyc  [NREQ];
  logic [NREQ-1:0] exp_gnt, exp_done, prev_gnt;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_gnt", gnt, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_clr", cnt_clr, 0);
    check("rst_en", cnt_en, 0);
    reset = 1'b1;
    @(negedge clk);

    // Single job: req[0], delay 5; this negedge is cycle 0
    set_delay(0, 8'd5);
    req = 4'b0001;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      check("single_gnt", gnt, (c <= 8) ? 4'b0001 : 4'b0000);
      check("single_clr", cnt_clr, (c == 1));
      check("single_en", cnt_en, (c >= 2 && c <= 6));
      check("single_done", done, (c == 8) ? 4'b0001 : 4'b0000);
      check("single_busy", busy, (c <= 8));
      if (c == 8) req = '0;
    end

    // Delay 0 on req[2]
    set_delay(2, 8'd0);
    req = 4'b0100;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check("d0_gnt", gnt, (c <= 3) ? 4'b0100 : 4'b0000);
      check("d0_done", done, (c == 3) ? 4'b0100 : 4'b0000);
      check("d0_en", cnt_en, 0);
      if (c == 3) req = '0;
    end

    // Delay 255 on req[2]: all-ones reached with no wrap
    set_delay(2, 8'd255);
    req = 4'b0100;
    for (int c = 1; c <= 259; c++) begin
      @(negedge clk);
      check("d255_done", done, (c == 258) ? 4'b0100 : 4'b0000);
      check("d255_en", cnt_en, (c >= 2 && c <= 256));
      if (c == 257) check("d255_peak", cnt_value, 8'hFF);
      if (c == 258) req = '0;
    end
    check("d255_nowrap", wrapped, 0);

    // Round-robin with all requests held, then a partial request set
    pulse_reset();
    for (int i = 0; i < NREQ; i++) set_delay(i, 8'd1);
    req = 4'b1111;
    wait_grant(0, "rr_g0");
    wait_grant(1, "rr_g1");
    wait_grant(2, "rr_g2");
    wait_grant(3, "rr_g3");
    wait_grant(0, "rr_g4");
    wait_done(4'b0001, "rr_d4");
    req = 4'b0010;
    wait_grant(1, "rr_g5");
    wait_done(4'b0010, "rr_d5");
    req = 4'b1010;
    wait_grant(3, "rr_g6");
    wait_done(4'b1000, "rr_d6");
    wait_grant(1, "rr_g7");
    wait_done(4'b0010, "rr_d7");
    req = '0;

    // Abort: req[1] drops at cnt_value 4
    set_delay(1, 8'd10);
    @(negedge clk);
    req = 4'b0010;
    wait_grant(1, "abort_gnt");
    for (int k = 0; k < 50; k++) begin
      if (cnt_value == 8'd4 && cnt_en) break;
      @(negedge clk);
    end
    check("abort_at4", cnt_value, 8'd4);
    req = '0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_gnt0", gnt, 0);
    check("abort_en", cnt_en, 0);
    check("abort_nodone", done, 0);
    @(negedge clk);
    check("abort_nodone2", done, 0);
    set_delay(0, 8'd2);
    set_delay(3, 8'd2);
    req = 4'b1001;
    wait_grant(3, "abort_next");
    wait_done(4'b1000, "abort_next_done");
    req = '0;

    // Asynchronous reset mid-RUN
    set_delay(3, 8'd20);
    @(negedge clk);
    req = 4'b1000;
    wait_grant(3, "arst_gnt");
    for (int k = 0; k < 50; k++) begin
      if (cnt_value == 8'd3 && busy) break;
      @(negedge clk);
    end
    check("arst_at3", cnt_value, 8'd3);
    reset = 1'b0;
    #1;
    check("arst_gnt0", gnt, 0);
    check("arst_done0", done, 0);
    check("arst_busy0", busy, 0);
    check("arst_clr0", cnt_clr, 0);
    check("arst_en0", cnt_en, 0);
    @(negedge clk);
    reset = 1'b1;
    wait_grant(3, "arst_regrant");
    wait_done(4'b1000, "arst_redone");
    req = '0;

    // Random traffic against the job-level model
    pulse_reset();
    m_left = 0; m_owner = 0; m_ptr = 0;
    prev_gnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      r_req[i] = 1'b0; r_del[i] = 0; gcyc[i] = 0;
    end
    for (int t = 0; t < 2000; t++) begin
      exp_gnt  = (m_left > 0) ? (NREQ'(1) << m_owner) : '0;
      exp_done = (m_left == 1) ? exp_gnt : '0;
      check("rnd_gnt", gnt, exp_gnt);
      check("rnd_done", done, exp_done);
      check("rnd_busy", busy, (m_left > 0));
      check("rnd_onehot", $onehot0(gnt), 1);
      check("rnd_done_in_gnt", done & ~gnt, 0);
      check("rnd_clr_en", cnt_clr & cnt_en, 0);
      if (gnt != '0 && prev_gnt == '0 && idx_of(gnt) >= 0) gcyc[idx_of(gnt)] = t;
      if (done != '0 && idx_of(done) >= 0)
        check("rnd_latency", t - gcyc[idx_of(done)], r_del[idx_of(done)] + 2);
      prev_gnt = gnt;

      for (int i = 0; i < NREQ; i++) begin
        if (done[i]) r_req[i] = 1'b0;
        else if (!r_req[i] && t < 1800 && $urandom_range(0, 7) == 0) begin
          r_req[i] = 1'b1;
          r_del[i] = $urandom_range(0, 12);
        end
        req[i] = r_req[i];
        set_delay(i, WIDTH'(r_del[i]));
      end

      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_ptr = (m_owner + 1) % NREQ;
      end else begin
        for (int k = 0; k < NREQ; k++) begin
          if (r_req[(m_ptr + k) % NREQ]) begin
            m_owner = (m_ptr + k) % NREQ;
            m_left  = r_del[m_owner] + 3;
            break;
          end
        end
      end
      @(negedge clk);
    end
    check("drain_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
